// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the wishbone configuration loader.
//   - register offsets (word offset = wbs_addr_i[3:2])
//   - STATUS register bit positions
//   - loader FSM state encoding
package fpga_cfg_pkg;

    localparam logic [1:0] CFG_OFF_DATA   = 2'd0;
    localparam logic [1:0] CFG_OFF_CTRL   = 2'd1;
    localparam logic [1:0] CFG_OFF_STATUS = 2'd2;

    localparam int ST_BUSY     = 0;
    localparam int ST_DONE     = 1;
    localparam int ST_FULL     = 2;
    localparam int ST_EMPTY    = 3;
    localparam int ST_CNT_LSB  = 4;   // [7:4] fifo_count
    localparam int ST_WCNT_LSB = 16;  // [31:16] word_cnt

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LOAD  = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/fpga_cfg_fifo.sv
// Synchronous word FIFO for the configuration loader.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        empties the FIFO (pointers and count to 0)
//   push, wdata  write a word (caller guarantees no push while full without pop)
//   pop, rdata   read side; rdata shows the head word combinationally
//   full, empty, count
module fpga_cfg_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/fpga_wb_cfg_loader.sv
// Wishbone slave that buffers 32-bit bitstream words and shifts them LSB-first
// onto the fabric configuration chain; after CFG_WORDS words it pulses
// cfg_load_o so the fabric adopts the new configuration.
// Ports:
//   wb_clk_i, wb_rst_ni                 clock, asynchronous active-low reset
//   wbs_stb_i/cyc_i/we_i/sel_i/data_i/addr_i, wbs_ack_o/data_o   wishbone slave
//   cfg_en_o, cfg_data_o                chain shift enable / serial data
//   cfg_load_o                          one-cycle latch pulse
//   cfg_busy_o                          FSM not in IDLE
module fpga_wb_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] CFG_WORDS  = 16'd64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_data_i,
    input  logic [31:0] wbs_addr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_data_o,
    output logic        cfg_en_o,
    output logic        cfg_data_o,
    output logic        cfg_load_o,
    output logic        cfg_busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    cfg_state_t    state, state_nx;
    logic [31:0]   sr;
    logic [4:0]    bit_cnt;
    logic [15:0]   word_cnt;
    logic          done, enabled;

    logic          req, data_wr, accept, start, push, pop;
    logic          word_inc, set_done;
    logic [1:0]    off;
    logic [31:0]   fifo_rdata, status, rdata_mux;
    logic          fifo_full, fifo_empty;
    logic [AW:0]   fifo_cnt;
    logic [7:0]    cnt8;

    // Byte selects and the low/middle address bits carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{wbs_sel_i, wbs_addr_i[7:4], wbs_addr_i[1:0]};

    // ---------------- wishbone decode ----------------
    assign off     = wbs_addr_i[3:2];
    assign req     = wbs_stb_i & wbs_cyc_i & (wbs_addr_i[31:8] == BASE_ADDR[31:8]) & ~wbs_ack_o;
    assign data_wr = req & wbs_we_i & (off == CFG_OFF_DATA);
    // A DATA write to a full FIFO waits unless a pop frees a slot this cycle.
    assign accept  = req & ~(data_wr & fifo_full & ~pop);
    assign push    = accept & data_wr;
    // CTRL writes are never stalled, so START is decoded from req directly;
    // this keeps pop -> accept -> start -> pop free of a combinational loop.
    assign start   = req & wbs_we_i & (off == CFG_OFF_CTRL) & wbs_data_i[0];

    assign cnt8 = 8'(fifo_cnt);
    always_comb begin
        status                        = '0;
        status[ST_BUSY]               = (state != IDLE);
        status[ST_DONE]               = done;
        status[ST_FULL]               = fifo_full;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_CNT_LSB +: 4]       = cnt8[3:0];
        status[ST_WCNT_LSB +: 16]     = word_cnt;
    end

    assign rdata_mux = (off == CFG_OFF_STATUS) ? status : 32'd0;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wbs_ack_o  <= 1'b0;
            wbs_data_o <= '0;
        end else begin
            wbs_ack_o  <= accept;
            wbs_data_o <= (accept && !wbs_we_i) ? rdata_mux : 32'd0;
        end
    end

    fpga_cfg_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
        .clk   (wb_clk_i),
        .rst_n (wb_rst_ni),
        .flush (start),
        .push  (push),
        .wdata (wbs_data_i),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        word_inc = 1'b0;
        set_done = 1'b0;
        case (state)
            IDLE: begin
                if (enabled && !fifo_empty) begin
                    pop      = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == 5'd31) begin
                    word_inc = 1'b1;
                    if (word_cnt + 16'd1 == CFG_WORDS) state_nx = LOAD;
                    else if (!fifo_empty)              pop      = 1'b1;  // no bubble
                    else                               state_nx = IDLE;
                end
            end
            LOAD: begin
                set_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // START overrides everything, including a pending move into LOAD.
        if (start) begin
            state_nx = IDLE;
            pop      = 1'b0;
        end
    end

    // ---------------- shifter / counters ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            sr       <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
            enabled  <= 1'b1;
        end else begin
            if (start) begin
                word_cnt <= '0;
                done     <= 1'b0;
                enabled  <= 1'b1;
            end else begin
                if (word_inc) word_cnt <= word_cnt + 16'd1;
                if (set_done) begin
                    done    <= 1'b1;
                    enabled <= 1'b0;
                end
            end
            if (pop) begin
                sr      <= fifo_rdata;
                bit_cnt <= '0;
            end else if (state == SHIFT) begin
                sr      <= sr >> 1;
                bit_cnt <= bit_cnt + 5'd1;
            end
        end
    end

    assign cfg_en_o   = (state == SHIFT);
    assign cfg_data_o = cfg_en_o & sr[0];
    assign cfg_load_o = (state == LOAD);
    assign cfg_busy_o = (state != IDLE);

endmodule

// File: tb/tb_fpga_wb_cfg_loader.sv
// Directed bench for fpga_wb_cfg_loader. Two instances share the bus wires:
// dut_a has CFG_WORDS=1, dut_b has CFG_WORDS=8; tgt selects which sees cyc.
module tb_fpga_wb_cfg_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] A_DATA = BASE + 32'h0;
    localparam logic [31:0] A_CTRL = BASE + 32'h4;
    localparam logic [31:0] A_STAT = BASE + 32'h8;
    localparam logic [31:0] A_RSVD = BASE + 32'hC;

    logic        clk, rst_n;
    logic        stb, cyc, we, tgt;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic        cyc_a, cyc_b;

    logic        ack_a, en_a, dat_a, load_a, busy_a;
    logic        ack_b, en_b, dat_b, load_b, busy_b;
    logic [31:0] rd_a, rd_b;
    logic        ack_m;
    logic [31:0] rd_m;

    int vectors = 0;
    int errs    = 0;

    assign cyc_a = cyc & ~tgt;
    assign cyc_b = cyc & tgt;
    assign ack_m = tgt ? ack_b : ack_a;
    assign rd_m  = tgt ? rd_b : rd_a;

    fpga_wb_cfg_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .CFG_WORDS(16'd1)) dut_a (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc_a), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_data_i(wdat), .wbs_addr_i(adr),
        .wbs_ack_o(ack_a), .wbs_data_o(rd_a),
        .cfg_en_o(en_a), .cfg_data_o(dat_a), .cfg_load_o(load_a), .cfg_busy_o(busy_a)
    );

    fpga_wb_cfg_loader #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .CFG_WORDS(16'd8)) dut_b (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc_b), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_data_i(wdat), .wbs_addr_i(adr),
        .wbs_ack_o(ack_b), .wbs_data_o(rd_b),
        .cfg_en_o(en_b), .cfg_data_o(dat_b), .cfg_load_o(load_b), .cfg_busy_o(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Chain monitor for dut_b: length of the current cfg_en run, longest run,
    // total enabled cycles and number of load pulses.
    int run_b = 0, max_b = 0, tot_b = 0, loads_b = 0;
    always @(posedge clk) begin
        if (en_b) begin
            run_b <= run_b + 1;
            tot_b <= tot_b + 1;
            if (run_b + 1 > max_b) max_b <= run_b + 1;
        end else begin
            run_b <= 0;
        end
        if (load_b) loads_b <= loads_b + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One wishbone access, starting and ending on a falling edge.
    task automatic wb_xfer(input logic t, input logic w, input logic [31:0] a,
                           input logic [31:0] d, output logic [31:0] rd, output int waited);
        tgt = t; we = w; adr = a; wdat = d; stb = 1'b1; cyc = 1'b1;
        waited = 0;
        do begin
            @(posedge clk); @(negedge clk);
            waited++;
        end while (!ack_m && waited < 100);
        check("ack_arrived", {31'b0, ack_m}, 32'd1);
        rd = rd_m;
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, exp_w;
        int          wt, n, acks;
        int          wt1, wt5, wt6;

        rst_n = 1'b0; stb = 0; cyc = 0; we = 0; tgt = 0; sel = 4'hF;
        wdat = '0; adr = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {26'b0, ack_a, en_a, dat_a, load_a, busy_a, ack_b},  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: STATUS after reset
        wb_xfer(0, 0, A_STAT, 0, rd, wt);
        check("t1_status", rd, 32'h0000_0008);
        check("t1_cfg_idle", {28'b0, en_a, dat_a, load_a, busy_a}, 32'd0);

        // 2: single-word bitstream on dut_a
        exp_w = 32'hA5A5_0001;
        wb_xfer(0, 1, A_DATA, exp_w, rd, wt);
        check("t2_wr_rdata", rd, 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check($sformatf("t2_bit%0d", i), {30'b0, en_a, dat_a}, {30'b0, 1'b1, exp_w[i]});
        end
        @(negedge clk);
        check("t2_load", {30'b0, load_a, en_a}, 32'd2);
        @(negedge clk);
        check("t2_after", {30'b0, load_a, busy_a}, 32'd0);
        wb_xfer(0, 0, A_STAT, 0, rd, wt);
        check("t2_status", rd, 32'h0001_000A);
        // after done, data buffers but does not shift
        wb_xfer(0, 1, A_DATA, 32'h1234_5678, rd, wt);
        repeat (3) @(negedge clk);
        check("t2_no_shift", {30'b0, busy_a, en_a}, 32'd0);
        wb_xfer(0, 0, A_STAT, 0, rd, wt);
        check("t2_status_done", rd, 32'h0001_0012);

        // 3: six back-to-back words on dut_b (FIFO depth 4)
        wb_xfer(1, 1, A_DATA, 32'h0000_0001, rd, wt1);
        wb_xfer(1, 1, A_DATA, 32'h0000_0002, rd, wt);
        wb_xfer(1, 1, A_DATA, 32'h0000_0003, rd, wt);
        wb_xfer(1, 1, A_DATA, 32'h0000_0004, rd, wt);
        wb_xfer(1, 1, A_DATA, 32'h0000_0005, rd, wt5);
        wb_xfer(1, 1, A_DATA, 32'h0000_0006, rd, wt6);
        check("t3_wait_w1", wt1, 32'd1);
        check("t3_wait_w5", wt5, 32'd2);
        check("t3_wait_w6_stall", wt6, 32'd25);
        n = 0;
        while (busy_b && n < 400) begin @(negedge clk); n++; end
        check("t3_idle", {31'b0, busy_b}, 32'd0);
        check("t3_max_run", max_b, 32'd192);
        check("t3_total_en", tot_b, 32'd192);
        check("t3_no_load", loads_b, 32'd0);
        wb_xfer(1, 0, A_STAT, 0, rd, wt);
        check("t3_status", rd, 32'h0006_0008);

        // 4: START during bit 10 of word 2
        wb_xfer(1, 1, A_CTRL, 32'd1, rd, wt);
        wb_xfer(1, 0, A_STAT, 0, rd, wt);
        check("t4_start_clr", rd, 32'h0000_0008);
        wb_xfer(1, 1, A_DATA, 32'hFFFF_FFFF, rd, wt);
        wb_xfer(1, 1, A_DATA, 32'hFFFF_FFFF, rd, wt);
        wb_xfer(1, 1, A_DATA, 32'hFFFF_FFFF, rd, wt);
        n = 0;
        while (run_b != 42 && n < 300) begin @(negedge clk); n++; end
        check("t4_reach_bit42", run_b, 32'd42);
        check("t4_shifting", {30'b0, en_b, dat_b}, 32'd3);
        wb_xfer(1, 1, A_CTRL, 32'd1, rd, wt);
        check("t4_en_drop", {29'b0, en_b, load_b, busy_b}, 32'd0);
        repeat (5) @(negedge clk);
        check("t4_stays_idle", {30'b0, en_b, busy_b}, 32'd0);
        wb_xfer(1, 0, A_STAT, 0, rd, wt);
        check("t4_status", rd, 32'h0000_0008);
        check("t4_no_load", loads_b, 32'd0);

        // 5: out-of-base access and reserved offset
        tgt = 0; we = 1; adr = BASE + 32'h100; wdat = 32'hDEAD_BEEF; stb = 1; cyc = 1;
        acks = 0;
        repeat (20) begin @(negedge clk); if (ack_a) acks++; end
        stb = 0; cyc = 0; we = 0;
        check("t5_no_ack", acks, 32'd0);
        wb_xfer(0, 1, A_RSVD, 32'hFFFF_FFFF, rd, wt);
        wb_xfer(0, 0, A_RSVD, 0, rd, wt);
        check("t5_rsvd_rd", rd, 32'd0);
        wb_xfer(0, 0, A_DATA, 0, rd, wt);
        check("t5_data_rd", rd, 32'd0);
        wb_xfer(0, 0, A_STAT, 0, rd, wt);
        check("t5_status_unchanged", rd, 32'h0001_0012);

        // 6: asynchronous reset mid-shift
        wb_xfer(1, 1, A_DATA, 32'hFFFF_FFFF, rd, wt);
        repeat (5) @(negedge clk);
        check("t6_pre_shift", {30'b0, en_b, dat_b}, 32'd3);
        #2 rst_n = 1'b0;
        #1 check("t6_async_rst", {22'b0, ack_a, en_a, dat_a, load_a, busy_a,
                                  ack_b, en_b, dat_b, load_b, busy_b}, 32'd0);
        check("t6_rst_rdata", rd_b, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        wb_xfer(1, 0, A_STAT, 0, rd, wt);
        check("t6_status_b", rd, 32'h0000_0008);
        wb_xfer(0, 0, A_STAT, 0, rd, wt);
        check("t6_status_a", rd, 32'h0000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
